// File: rtl/key_click_classifier_pkg.sv
// Shared key-input definitions: FSM state encoding and default timing
// parameters used by both the debounce stage and the click classifier.
package key_click_classifier_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } key_state_e;

    localparam int CLICK_WINDOW_DEF = 14400000;  // 300 ms at 48 MHz
    localparam int MAX_CLICKS_DEF   = 3;
    localparam int CNT_BITS_DEF     = 24;
    localparam int CLICK_BITS       = 2;

endpackage

// File: rtl/key_click_classifier_if.sv
// Click-event handshake: one-entry event slot with a drop indication.
interface key_click_classifier_if;
    import key_click_classifier_pkg::*;

    logic                  evt_valid;
    logic [CLICK_BITS-1:0] evt_clicks;
    logic                  evt_ready;
    logic                  evt_drop;

    modport master (output evt_valid, evt_clicks, evt_drop, input evt_ready);
    modport slave  (input evt_valid, evt_clicks, evt_drop, output evt_ready);
endinterface

// File: rtl/key_click_classifier_evt_slot.sv
// One-entry registered output slot for completed click sequences; a completion
// that finds the slot full and not being drained is discarded with a drop pulse.
module key_evt_slot
    import key_click_classifier_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  complete,
    input  logic [CLICK_BITS-1:0] done_clicks,
    key_click_classifier_if.master evt
);

    logic slot_free;
    assign slot_free = !evt.evt_valid || evt.evt_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            evt.evt_valid  <= 1'b0;
            evt.evt_clicks <= '0;
            evt.evt_drop   <= 1'b0;
        end else begin
            evt.evt_drop <= 1'b0;
            if (complete) begin
                if (slot_free) begin
                    evt.evt_valid  <= 1'b1;
                    evt.evt_clicks <= done_clicks;
                end else begin
                    evt.evt_drop <= 1'b1;
                end
            end else if (evt.evt_valid && evt.evt_ready) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_click_classifier.sv
// Groups debounced key presses into 1..MAX_CLICKS click events, closing a
// sequence after CLICK_WINDOW quiet cycles or immediately at MAX_CLICKS.
module key_click_classifier
    import key_click_classifier_pkg::*;
#(
    parameter int CLICK_WINDOW = CLICK_WINDOW_DEF,
    parameter int MAX_CLICKS   = MAX_CLICKS_DEF,
    parameter int CNT_BITS     = CNT_BITS_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_i,
    key_click_classifier_if.master evt
);

    localparam logic [CNT_BITS-1:0]   TIMER_LAST = CNT_BITS'(CLICK_WINDOW - 1);
    localparam logic [CLICK_BITS-1:0] CLICKS_MAX = CLICK_BITS'(MAX_CLICKS);

    key_state_e            state_q, state_d;
    logic [CLICK_BITS-1:0] clicks_q, clicks_d;
    logic [CNT_BITS-1:0]   timer_q, timer_d;
    logic [CLICK_BITS-1:0] clicks_inc;
    logic                  complete;
    logic [CLICK_BITS-1:0] done_clicks;

    assign clicks_inc = clicks_q + CLICK_BITS'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            clicks_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            clicks_q <= clicks_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clicks_d    = clicks_q;
        timer_d     = timer_q;
        complete    = 1'b0;
        done_clicks = clicks_q;
        case (state_q)
            IDLE: begin
                if (key_i) begin
                    // With MAX_CLICKS=1 the very first press already ends the sequence.
                    if (CLICKS_MAX == CLICK_BITS'(1)) begin
                        complete    = 1'b1;
                        done_clicks = CLICK_BITS'(1);
                    end else begin
                        state_d  = COUNT;
                        clicks_d = CLICK_BITS'(1);
                        timer_d  = '0;
                    end
                end
            end
            COUNT: begin
                // A press on the expiry edge is checked first so it keeps the sequence open.
                if (key_i) begin
                    done_clicks = clicks_inc;
                    if (clicks_inc == CLICKS_MAX) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        clicks_d = '0;
                    end else begin
                        clicks_d = clicks_inc;
                    end
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    clicks_d = '0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + CNT_BITS'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                clicks_d = '0;
                timer_d  = '0;
            end
        endcase
    end

    key_evt_slot u_slot (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .complete    (complete),
        .done_clicks (done_clicks),
        .evt         (evt)
    );

endmodule

// File: tb/tb_key_click_classifier.sv
// Directed bench: an abstract press-timestamp model is checked against the DUT
// every cycle, plus literal event edges/counts for each scenario.
module tb_key_click_classifier;

    localparam int W   = 16;
    localparam int MAX = 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_i   = 1'b0;

    key_click_classifier_if bus ();

    key_click_classifier #(
        .CLICK_WINDOW (W),
        .MAX_CLICKS   (MAX),
        .CNT_BITS     (5)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_i   (key_i),
        .evt     (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cur_e;

    // model: open sequence described by press count and edge of last press
    bit m_open;
    int m_n, m_last;
    bit m_valid, m_drop;
    int m_clicks;

    // per-scenario log of DUT behaviour
    int evt_cnt, first_edge, first_clicks, drop_cnt, drop_edge, fall_edge;
    bit prev_v;

    int pulses[$];
    int rst_edges[$];

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cur_e, act, exp);
        end
    endtask

    task automatic model_update(input bit k, input bit r, input bit rd, input int e);
        bit comp;
        int cn;
        comp = 1'b0;
        cn   = 0;
        if (r) begin
            m_open = 0; m_n = 0; m_valid = 0; m_clicks = 0; m_drop = 0;
            return;
        end
        if (k) begin
            m_n    = m_open ? m_n + 1 : 1;
            m_open = 1;
            m_last = e;
            if (m_n == MAX) begin comp = 1; cn = m_n; m_open = 0; end
        end else if (m_open && (e - m_last) == W) begin
            comp = 1; cn = m_n; m_open = 0;
        end
        m_drop = 0;
        if (comp) begin
            if (!m_valid || rd) begin m_valid = 1; m_clicks = cn; end
            else m_drop = 1;
        end else if (m_valid && rd) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit k, input bit r, input bit rd);
        key_i         = k;
        sys_rst       = r;
        bus.evt_ready = rd;
        @(posedge sys_clk);
        model_update(k, r, rd, cur_e);
        #1;
        cmp("evt_valid", int'(bus.evt_valid), int'(m_valid));
        cmp("evt_drop", int'(bus.evt_drop), int'(m_drop));
        if (m_valid || r) cmp("evt_clicks", int'(bus.evt_clicks), m_clicks);
        if (bus.evt_valid && !prev_v) begin
            evt_cnt++;
            if (first_edge < 0) begin
                first_edge   = cur_e;
                first_clicks = int'(bus.evt_clicks);
            end
        end
        if (!bus.evt_valid && prev_v) fall_edge = cur_e;
        if (bus.evt_drop) begin drop_cnt++; drop_edge = cur_e; end
        prev_v = bus.evt_valid;
    endtask

    task automatic run(input int n, input int rdy_lo, input int rdy_hi);
        bit k, r;
        cur_e = 0;
        step(0, 1, 1);
        step(0, 1, 1);
        evt_cnt = 0; first_edge = -1; first_clicks = -1;
        drop_cnt = 0; drop_edge = -1; fall_edge = -1; prev_v = 0;
        for (int e = 1; e <= n; e++) begin
            cur_e = e;
            k = 0;
            r = 0;
            foreach (pulses[i]) if (pulses[i] == e) k = 1;
            foreach (rst_edges[i]) if (rst_edges[i] == e) r = 1;
            step(k, r, !(e >= rdy_lo && e <= rdy_hi));
        end
        key_i = 0;
        sys_rst = 0;
    endtask

    initial begin
        bus.evt_ready = 1'b1;

        // single click
        pulses = '{10}; rst_edges = {};
        run(40, 0, -1);
        cmp("single_edge", first_edge, 26);
        cmp("single_clicks", first_clicks, 1);
        cmp("single_count", evt_cnt, 1);
        cmp("single_fall", fall_edge, 27);

        // double click, nothing at edge 26
        pulses = '{10, 15};
        run(45, 0, -1);
        cmp("double_edge", first_edge, 31);
        cmp("double_clicks", first_clicks, 2);
        cmp("double_count", evt_cnt, 1);

        // max clicks completes at once; edge 20 opens a new sequence
        pulses = '{10, 12, 14, 20};
        run(45, 0, -1);
        cmp("max_edge", first_edge, 14);
        cmp("max_clicks", first_clicks, 3);
        cmp("max_count", evt_cnt, 2);

        // press exactly on expiry keeps the sequence open
        pulses = '{10, 26};
        run(50, 0, -1);
        cmp("boundary_edge", first_edge, 42);
        cmp("boundary_clicks", first_clicks, 2);
        cmp("boundary_count", evt_cnt, 1);

        // back-pressure: second completion at 60 dropped, ready raised at 63
        pulses = '{10, 44};
        run(70, 1, 62);
        cmp("bp_edge", first_edge, 26);
        cmp("bp_clicks", first_clicks, 1);
        cmp("bp_drop_edge", drop_edge, 60);
        cmp("bp_drop_count", drop_cnt, 1);
        cmp("bp_fall", fall_edge, 63);

        // reset mid-sequence, colliding with a press
        pulses = '{10, 20, 30}; rst_edges = '{20};
        run(60, 0, -1);
        cmp("rst_edge", first_edge, 46);
        cmp("rst_count", evt_cnt, 1);
        cmp("rst_drops", drop_cnt, 0);

        // press on first edge after reset
        pulses = '{1}; rst_edges = {};
        run(25, 0, -1);
        cmp("post_rst_edge", first_edge, 17);
        cmp("post_rst_clicks", first_clicks, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
